// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of the 64-entry byte FIFO.
// A burst is admitted only when the FIFO has room for all of its beats.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 64,
  parameter int LW    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LW-1:0]      req_len,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         ack,
  output logic                    fifo_wr_en,
  output logic [DW-1:0]           fifo_din,
  input  logic [7:0]              fifo_counter,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] owner
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state_r;
  logic [PW-1:0]   owner_r;
  logic [LW-1:0]   beats_left_r;
  logic [PW-1:0]   rr_ptr_r;

  logic [8:0]      space_s;
  logic [8:0]      need_s;
  logic            cand_found_s;
  logic [PW-1:0]   cand_s;
  logic [PW-1:0]   idx_s;
  logic [LW-1:0]   cand_len_s;
  logic            fits_s;

  // Free FIFO space and the round-robin head-of-line candidate.
  always_comb begin
    if ({1'b0, fifo_counter} > 9'(DEPTH)) begin
      space_s = 9'd0;
    end else begin
      space_s = 9'(DEPTH) - {1'b0, fifo_counter};
    end
    cand_found_s = 1'b0;
    cand_s       = '0;
    idx_s        = '0;
    // Walk from the farthest slot back to rr_ptr so the nearest request wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx_s = rr_ptr_r + PW'(k);
      if (req[idx_s]) begin
        cand_found_s = 1'b1;
        cand_s       = idx_s;
      end else begin
        cand_found_s = cand_found_s;
      end
    end
    cand_len_s = req_len[cand_s*LW +: LW];
    need_s     = 9'(cand_len_s) + 9'd1;
    fits_s     = (space_s >= need_s);
  end

  // Arbitration and burst sequencing state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      owner_r      <= '0;
      beats_left_r <= '0;
      rr_ptr_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cand_found_s && fits_s) begin
            owner_r      <= cand_s;
            beats_left_r <= cand_len_s;
            rr_ptr_r     <= cand_s + PW'(1);
            state_r      <= BURST;
          end else begin
            state_r <= IDLE;
          end
        end
        BURST: begin
          // A dropped request aborts; remaining beats are discarded.
          if (!req[owner_r] || (beats_left_r == '0)) begin
            state_r <= IDLE;
          end else begin
            beats_left_r <= beats_left_r - LW'(1);
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Write-port decode from the granted requester.
  always_comb begin
    ack        = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    if (state_r == BURST) begin
      fifo_wr_en    = req[owner_r];
      ack[owner_r]  = req[owner_r];
      fifo_din      = req_data[owner_r*DW +: DW];
    end else begin
      ack        = '0;
      fifo_wr_en = 1'b0;
      fifo_din   = '0;
    end
  end

  assign busy  = (state_r == BURST);
  assign owner = owner_r;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the team's 64-entry, 8-bit `fifo` among `NREQ` requesters. Each requester asks for a burst of 1–8 bytes. The arbiter admits a burst only when the FIFO has room for the whole burst, so bursts land contiguously and no byte is dropped on `buf_full`. It sits directly in front of `fifo`: it drives `wr_en`/`buf_in` and reads back `fifo_counter`.

## Interface

Parameters:
- `NREQ`, 4: number of requesters; power of two, ≥ 2.
- `DW`, 8: data width; matches FIFO `buf_in`.
- `DEPTH`, 64: FIFO capacity in entries.
- `LW`, 3: burst length field width; burst = `len + 1` beats.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req`, in, `NREQ`: per-requester burst request; held high until the last `ack`.
- `req_len`, in, `NREQ*LW`: requester i's length in bits `[i*LW +: LW]`; stable while `req[i]` is high.
- `req_data`, in, `NREQ*DW`: requester i's current byte in `[i*DW +: DW]`.
- `ack`, out, `NREQ`: one-hot; `ack[i]` means requester i's byte is written this cycle and it must present the next byte.
- `fifo_wr_en`, out, 1: to FIFO `wr_en`.
- `fifo_din`, out, `DW`: to FIFO `buf_in`.
- `fifo_counter`, in, 8: from FIFO occupancy (0..`DEPTH`).
- `busy`, out, 1: high in BURST.
- `owner`, out, `log2(NREQ)`: current/last granted requester.

## Operation

- Registered state: `state` (IDLE, BURST), `owner`, `beats_left` (`LW` bits), `rr_ptr` (`log2(NREQ)` bits).
- `space = DEPTH - fifo_counter`, computed at ≥ 8 bits with no wrap. A `fifo_counter` above `DEPTH` is treated as `space = 0`.
- **IDLE:**
  - Candidate `c` = first index with `req` high, searching `rr_ptr, rr_ptr+1, …` modulo `NREQ`.
  - If a candidate exists and `space ≥ len[c] + 1`: `owner <= c`, `beats_left <= len[c]`, `rr_ptr <= c + 1` (mod `NREQ`), `state <= BURST`.
  - If the candidate does not fit: no grant; hold and retry every cycle. Never skip to a later, smaller request (head-of-line by design, starvation-free).
- **BURST:**
  - `fifo_wr_en = req[owner]`, `ack[owner] = req[owner]`, `fifo_din = req_data[owner]`.
  - On a beat with `beats_left == 0`: `state <= IDLE`. Otherwise `beats_left <= beats_left - 1`.
  - `req[owner]` low mid-burst: abort. No write that cycle, `state <= IDLE`, remaining beats discarded. `rr_ptr` is already advanced.
- Outside BURST: `fifo_wr_en = 0`, `ack = 0`, `fifo_din = 0`.
- Output decodes are combinational from registered state plus `req`/`req_data` only. No path from `fifo_counter` to `fifo_wr_en`.
- `busy = (state == BURST)`. `owner` holds its last value in IDLE.

## Timing

- Reset (async, on `rst_n` low, immediately):
  - State: `state = IDLE`, `owner = 0`, `beats_left = 0`, `rr_ptr = 0`.
  - Outputs: `ack = 0`, `fifo_wr_en = 0`, `fifo_din = 0`, `busy = 0`.
  - A partial burst already written stays in the FIFO.
- Grant latency: request seen in IDLE at edge k → first `fifo_wr_en` in cycle k+1.
- Burst of length L: exactly L+1 consecutive write cycles, then one mandatory IDLE cycle. Peak throughput is (L+1)/(L+2).
- The admission check uses the `fifo_counter` sampled in IDLE. The FIFO updates its counter on the same edge as each write, so the IDLE cycle after a burst sees the settled count.
- Concurrent FIFO reads only increase space; an admitted burst never hits `buf_full`.
- Exact fit (`space == len + 1`): admit. The burst ends with the FIFO at 64 and `buf_full` high.

## Test plan

- **Single burst:** `fifo_counter = 0`, `req[2] = 1`, `len = 3`, data 0xA0..0xA3. Expect `fifo_wr_en` high for 4 cycles starting one cycle after the request, `ack = 4'b0100` each beat, `fifo_din` A0, A1, A2, A3, then `busy` drops; `owner = 2`, `rr_ptr = 3`.
- **Round-robin:** all four `req` high, `len = 0`, held continuously. Grant order 0, 1, 2, 3, 0, with each single write separated by one IDLE cycle.
- **Space check:** `fifo_counter = 61`, `req[0]`, `len = 3` → no grant. Drop `fifo_counter` to 60 → grant next edge, 4 writes. Also with `req[1]` `len = 0` pending and `rr_ptr = 0`, `req[1]` is not granted while `req[0]` is blocked.
- **Abort:** `req[1]`, `len = 7`; deassert `req[1]` after 3 acks. Expect exactly 3 writes, return to IDLE, next grant search starting at index 2.
- **Reset mid-burst:** pull `rst_n` low during beat 2 of a 6-beat burst. `fifo_wr_en`/`ack` go low asynchronously; after release, `rr_ptr = 0` and requester 0 wins over 3.
- **Exact fit:** `fifo_counter = 56`, `len = 7`. Admitted; 8 writes; the FIFO reaches 64 with no write attempted while full.
